// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO behind the UART receiver with level irq and flush
// Optional drop-on-full with sticky overrun: define UART_RX_FIFO_DROP_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] level,
  output logic             irq_level,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == FULL_LVL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;
  assign pop       = out_valid && out_ready;

`ifdef UART_RX_FIFO_DROP_EN
  logic drop;

  // Receiver is never stalled; a full FIFO only takes a byte if a pop frees a slot.
  assign in_ready = reset_n;
  assign push     = in_valid && reset_n && (!full || pop);
  assign drop     = in_valid && reset_n && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_clr_overrun;

  assign in_ready           = reset_n && !full;
  assign push               = in_valid && in_ready;
  assign overrun            = 1'b0;
  assign unused_clr_overrun = clr_overrun;
`endif

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      irq_level <= 1'b0;
    end else begin
      count     <= count_nxt;
      // Built from next-state level so the irq moves in the same cycle as level.
      irq_level <= (threshold != '0) && (count_nxt >= threshold);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] level;
  logic             irq_level;
  logic             overrun;
  logic             clr_overrun;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .threshold(threshold), .level(level),
    .irq_level(irq_level), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Pops are checked on the falling edge, away from the edge that performs them.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_data: got 0x%02h, expected nothing queued", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data: got 0x%02h, expected 0x%02h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    flush = 1'b0; threshold = '0; clr_overrun = 1'b0;
    tick(); tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_irq", int'(irq_level), 0);
    check("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    tick();
    check("release_in_ready", int'(in_ready), 1);

    // Three bytes, fall-through visible one cycle after the first push.
    in_valid = 1'b1; in_data = 8'h55; exp_q.push_back(8'h55);
    tick();
    check("fwft_valid", int'(out_valid), 1);
    check("fwft_data", int'(out_data), 8'h55);
    push_byte(8'hAA);
    push_byte(8'h0F);
    in_valid = 1'b0;
    check("level3", int'(level), 3);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("drain3_level", int'(level), 0);
    check("drain3_valid", int'(out_valid), 0);

    // Fill, hold 17th byte, pop one, accept it, drain across the wrap.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("full_level", int'(level), 16);
    check("full_in_ready", int'(in_ready), 0);
    in_data = 8'h10;
    tick();
    check("held_in_ready", int'(in_ready), 0);
    check("held_level", int'(level), 16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_pop_in_ready", int'(in_ready), 1);
    check("after_pop_level", int'(level), 15);
    exp_q.push_back(8'h10);
    tick();
    in_valid = 1'b0;
    check("refill_level", int'(level), 16);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    check("wrap_drain_level", int'(level), 0);

    // Steady streaming at level 4.
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'hB0 + 8'(i));
      check("stream_level", int'(level), 4);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    check("stream_drain_level", int'(level), 0);

    // Level interrupt.
    threshold = 5'd8;
    for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
    in_valid = 1'b0;
    check("irq_below", int'(irq_level), 0);
    push_byte(8'hC7);
    in_valid = 1'b0;
    check("irq_at_level", int'(level), 8);
    check("irq_at", int'(irq_level), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("irq_after_pop", int'(irq_level), 0);
    threshold = 5'd0;
    for (int i = 0; i < 9; i++) push_byte(8'hC8 + 8'(i));
    in_valid = 1'b0;
    check("irq_thr0_level", int'(level), 16);
    check("irq_thr0", int'(irq_level), 0);
    threshold = 5'd17;
    tick();
    check("irq_thr17", int'(irq_level), 0);
    threshold = 5'd16;
    tick();
    check("irq_thr16", int'(irq_level), 1);
    threshold = 5'd0;

    // Flush, then flush racing a push and a pop.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_level", int'(level), 0);
    for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
    in_valid = 1'b0;
    check("pre_flush_level", int'(level), 5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("flush_race_level", int'(level), 0);
    check("flush_race_valid", int'(out_valid), 0);
    push_byte(8'h33);
    in_valid = 1'b0;
    check("post_flush_data", int'(out_data), 8'h33);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a fill.
    threshold = 5'd2;
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
    check("pre_rst_irq", int'(irq_level), 1);
    in_data = 8'hE3; reset_n = 1'b0;
    tick();
    exp_q.delete();
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_irq", int'(irq_level), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    in_valid = 1'b0; reset_n = 1'b1; threshold = 5'd0;
    tick();
    check("mid_rst_release", int'(in_ready), 1);

`ifdef UART_RX_FIFO_DROP_EN
    for (int i = 0; i < DEPTH; i++) push_byte(8'hF0 - 8'(i));
    in_valid = 1'b1; in_data = 8'hEE;
    check("drop_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("drop_level", int'(level), 16);
    check("drop_overrun", int'(overrun), 1);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    check("drop_drained", int'(level), 0);
    check("overrun_sticky", int'(overrun), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("overrun_clr", int'(overrun), 0);
`else
    for (int i = 0; i < DEPTH; i++) push_byte(8'hF0 - 8'(i));
    in_valid = 1'b1; in_data = 8'hEE; clr_overrun = 1'b1;
    tick();
    in_valid = 1'b0; clr_overrun = 1'b0;
    check("base_overrun", int'(overrun), 0);
    check("base_full_level", int'(level), 16);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    out_ready = 1'b0;
`endif

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte FIFO directly downstream of the UART receiver; consumes its ready/valid byte stream (data_out / data_out_valid / data_out_ready).
- Buffers received bytes so the host-side consumer (CPU MMIO read path) can drain in bursts without stalling the receiver.
- Provides fill level, a programmable level interrupt, and a flush.
- Single clock domain, same clock as the UART.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the level/threshold fields (holds 0..DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  8  byte from the UART receiver.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO accepts in_data this cycle.
- out_data  output  8  head-of-FIFO byte.
- out_valid  output  1  out_data valid (FIFO not empty).
- out_ready  input  1  consumer pops the head this cycle.
- flush  input  1  synchronous clear of all contents.
- threshold  input  CNT_W  level at which irq_level asserts; 0 disables the interrupt.
- level  output  CNT_W  current number of stored bytes.
- irq_level  output  1  level >= threshold and threshold != 0.
- overrun  output  1  sticky dropped-byte flag; only active with the optional feature, otherwise tied 0.
- clr_overrun  input  1  clears overrun; ignored without the optional feature.

Behaviour:
- Storage: DEPTH x 8 register array; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; level is a separate CNT_W counter.
- Push: in_valid && in_ready at a clk edge writes mem[wr_ptr]; wr_ptr+1; level+1.
- Pop: out_valid && out_ready at a clk edge; rd_ptr+1; level-1.
- out_data = mem[rd_ptr] combinationally (first-word fall-through).
- out_valid = (level != 0). A byte pushed at edge N is visible on out_valid/out_data in the cycle after edge N.
- in_ready = (level != DEPTH) && reset_n (base build).
- Push and pop in the same cycle: both pointers advance; level unchanged.
- Empty + push: no bypass; out_valid rises on the next cycle.
- Full: in_ready = 0, so the upstream holds the byte. No pass-through, even if out_ready = 1.
- Wrap: pointers roll DEPTH-1 -> 0 with no gap; order is preserved across the wrap.
- flush = 1 at an edge: pointers and level go to 0. flush overrides any push or pop in that cycle; the byte offered that cycle is discarded (in_ready is still reported per the level rule). Array contents are not cleared.
- irq_level is registered: updated from the next-state level, so it is valid the same cycle level changes. threshold > DEPTH means irq_level is never asserted.
- Reset (reset_n low at an edge, including mid-stream): level = 0, pointers = 0, out_valid = 0, irq_level = 0, overrun = 0. in_ready = 0 while reset_n is low; in_ready = 1 in the first cycle after release. Array contents are undefined and never exposed, because out_valid = 0.
- out_data value is don't-care when out_valid = 0.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_EN.
- Defined:
  - in_ready = reset_n (always 1 outside reset), so the receiver never back-pressures.
  - A push while full (level == DEPTH and no simultaneous pop) discards the byte and sets overrun on the next edge.
  - A push while full with a simultaneous pop is accepted normally.
  - clr_overrun = 1 clears overrun; if a drop occurs in the same cycle, the set wins.
  - flush does not clear overrun.
- Undefined: in_ready follows the base rule; overrun is constant 0; clr_overrun is unused.

Test Plan:
- Reset, then push 0x55, 0xAA, 0x0F with out_ready = 0 -> level = 3; out_data = 0x55 one cycle after the first push; pop order is 0x55, 0xAA, 0x0F; level returns to 0 and out_valid = 0.
- DEPTH=16: push 16 bytes 0x00..0x0F -> level = 16, in_ready = 0; with the 17th byte 0x10 held, pop one -> in_ready = 1; 0x10 accepted; drain order 0x01..0x10. Covers the pointer wrap.
- Continuous push and pop every cycle starting at level = 4 for 40 cycles -> level stays 4; output stream equals input stream delayed by 4 bytes.
- threshold = 8: push 7 bytes -> irq_level = 0; 8th byte -> irq_level = 1 in the same cycle level = 8; pop 1 -> irq_level = 0. threshold = 0 with a full FIFO -> irq_level = 0.
- level = 5, flush with simultaneous push 0x77 and pop -> next cycle level = 0, out_valid = 0; the following push of 0x33 makes out_data = 0x33.
- With UART_RX_FIFO_DROP_EN: fill 16 bytes, push 0xEE without a pop -> in_ready = 1, level stays 16, overrun = 1, 0xEE never appears on out_data; clr_overrun -> overrun = 0. Assert reset_n low mid-fill -> all outputs return to their reset values.
